// File: rtl/operand2_imm_encoder_pkg.sv
// Shared types and field helpers for the operand2 immediate encoder.
// Optional build macro: NEG_SEARCH_EN (adds a second pass on ~value).
package operand2_imm_encoder_pkg;
  localparam int ROT_W       = 4;
  localparam int NUM_ROT     = 16;
  localparam int IMM8_W      = 8;
  localparam int IMM12_W     = 12;
  localparam int IMM_ROT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic               found;
    logic               inverted;
    logic [IMM12_W-1:0] imm12;
  } enc_res_t;

  function automatic logic [IMM12_W-1:0] mk_imm12(input logic [ROT_W-1:0] rot,
                                                  input logic [IMM8_W-1:0] imm8);
    return {rot, imm8};
  endfunction
endpackage

// File: rtl/operand2_imm_encoder_if.sv
// Request/response handshake bundle for operand2_imm_encoder.
interface operand2_imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic        out_found;
  logic [11:0] out_imm12;
  logic        out_inverted;
  logic        out_c_from_rot;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_found, out_imm12, out_inverted, out_c_from_rot
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_found, out_imm12, out_inverted, out_c_from_rot
  );
endinterface

// File: rtl/operand2_imm_encoder_imm_rot_checker.sv
// One-rotation check: does ROL(value, 2*rot) fit in the low 8 bits?
module imm_rot_checker
  import operand2_imm_encoder_pkg::*;
(
  input  logic [31:0]       i_value,
  input  logic [ROT_W-1:0]  i_rot,
  output logic              o_match,
  output logic [IMM8_W-1:0] o_imm8
);
  logic [5:0]  w_sh;
  logic [31:0] w_rol;

  // A shift by 32 yields zero, so rot==0 needs no special case.
  assign w_sh    = {1'b0, i_rot, 1'b0};
  assign w_rol   = (i_value << w_sh) | (i_value >> (6'd32 - w_sh));
  assign o_match = (w_rol[31:IMM8_W] == '0);
  assign o_imm8  = w_rol[IMM8_W-1:0];
endmodule

// File: rtl/operand2_imm_encoder.sv
// Iterative search for an ARM {rot4, imm8} encoding of a 32-bit constant.
// Optional build macro: NEG_SEARCH_EN (second pass on ~value, MVN form).
module operand2_imm_encoder
  import operand2_imm_encoder_pkg::*;
#(
  parameter int LANES = 1
) (
  input logic                    clk,
  input logic                    rst,
  operand2_imm_encoder_if.slave  bus
);
  state_t               r_state, w_next;
  logic [31:0]          r_operand;
  logic [ROT_W-1:0]     r_rot;
  enc_res_t             r_res;

  // One-deep stage holding the previous group's outcome; the FSM decides on it.
  logic                 r_stg_vld;
  logic                 r_stg_hit;
  logic                 r_stg_last;
  logic                 r_stg_inv;
  logic [IMM12_W-1:0]   r_stg_imm12;

  logic [LANES-1:0]              w_lane_match;
  logic [LANES-1:0][IMM8_W-1:0]  w_lane_imm8;
  logic [LANES-1:0][ROT_W-1:0]   w_lane_rot;
  logic                          w_hit;
  logic [IMM12_W-1:0]            w_hit_imm12;
  logic                          w_group_last;
  logic                          w_pass_last;
  logic                          w_cur_inv;
  logic                          w_decide;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      assign w_lane_rot[g] = r_rot + ROT_W'(g);
      imm_rot_checker u_chk (
        .i_value (r_operand),
        .i_rot   (w_lane_rot[g]),
        .o_match (w_lane_match[g]),
        .o_imm8  (w_lane_imm8[g])
      );
    end
  endgenerate

  // Walk high to low so the lowest matching rotation is the last writer.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_imm12 = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (w_lane_match[i]) begin
        w_hit       = 1'b1;
        w_hit_imm12 = mk_imm12(w_lane_rot[i], w_lane_imm8[i]);
      end
    end
  end

  assign w_group_last = (r_rot == ROT_W'(NUM_ROT - LANES));
  assign w_decide     = r_stg_vld && (r_stg_hit || r_stg_last);

`ifdef NEG_SEARCH_EN
  logic r_pass;
  assign w_pass_last = r_pass;
  assign w_cur_inv   = r_pass;
`else
  assign w_pass_last = 1'b1;
  assign w_cur_inv   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.in_valid) w_next = ST_SEARCH;
      ST_SEARCH: if (w_decide)     w_next = ST_DONE;
      ST_DONE:   if (bus.out_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready       = (r_state == ST_IDLE);
    bus.out_valid      = (r_state == ST_DONE);
    bus.out_found      = r_res.found;
    bus.out_imm12      = r_res.imm12;
    bus.out_inverted   = r_res.inverted;
    bus.out_c_from_rot = r_res.found && (r_res.imm12[IMM12_W-1:IMM_ROT_LSB] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_operand   <= '0;
      r_rot       <= '0;
      r_res       <= '0;
      r_stg_vld   <= 1'b0;
      r_stg_hit   <= 1'b0;
      r_stg_last  <= 1'b0;
      r_stg_inv   <= 1'b0;
      r_stg_imm12 <= '0;
`ifdef NEG_SEARCH_EN
      r_pass      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_operand <= bus.in_value;
            r_rot     <= '0;
            r_stg_vld <= 1'b0;
`ifdef NEG_SEARCH_EN
            r_pass    <= 1'b0;
`endif
          end
        end
        ST_SEARCH: begin
          r_stg_vld   <= 1'b1;
          r_stg_hit   <= w_hit;
          r_stg_imm12 <= w_hit_imm12;
          r_stg_last  <= w_group_last && w_pass_last;
          r_stg_inv   <= w_cur_inv;
          r_rot       <= r_rot + ROT_W'(LANES);
`ifdef NEG_SEARCH_EN
          // Flip to ~value without a bubble; a late pass-0 hit still wins in the stage.
          if (w_group_last && !r_pass) begin
            r_pass    <= 1'b1;
            r_operand <= ~r_operand;
          end
`endif
          if (w_decide) begin
            r_res.found    <= r_stg_hit;
            r_res.inverted <= r_stg_hit && r_stg_inv;
            r_res.imm12    <= r_stg_hit ? r_stg_imm12 : '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
